// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared types and helpers for the multi-channel LED driver.
//   led_mode_t      - per-channel operating mode (OFF, ON, BLINK, BREATHE)
//   MODE_*_C        - raw 2-bit encodings of the config port mode field
//   calc_prescale() - clock cycles per prescaler tick
package led_pattern_pkg;

  localparam logic [1:0] MODE_OFF_C     = 2'd0;
  localparam logic [1:0] MODE_ON_C      = 2'd1;
  localparam logic [1:0] MODE_BLINK_C   = 2'd2;
  localparam logic [1:0] MODE_BREATHE_C = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF     = MODE_OFF_C,
    MODE_ON      = MODE_ON_C,
    MODE_BLINK   = MODE_BLINK_C,
    MODE_BREATHE = MODE_BREATHE_C
  } led_mode_t;

  function automatic int unsigned calc_prescale(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_channel.sv
// led_channel: one LED output with its own mode, rate and pattern state.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_tick         - shared prescaler tick (one cycle)
//   i_pwm          - shared free-running PWM count
//   i_we           - decoded config write for this channel
//   i_mode, i_rate - config values loaded on i_we
//   o_led          - registered LED drive, 1 = lit
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned RATE_BITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic [PWM_BITS-1:0]  i_pwm,
  input  logic                 i_we,
  input  led_mode_t            i_mode,
  input  logic [RATE_BITS-1:0] i_rate,
  output logic                 o_led
);

  localparam logic [PWM_BITS-1:0] BrightMax = {PWM_BITS{1'b1}};

  led_mode_t            r_mode;
  logic [RATE_BITS-1:0] r_rate;
  logic [RATE_BITS-1:0] r_cnt;
  logic                 r_phase;
  logic [PWM_BITS-1:0]  r_bright;
  logic                 r_dir_down;
  logic                 r_led;

  logic w_step;
  logic w_lit;
  logic w_led_d;

  always_comb begin
    w_step = i_tick && (r_cnt == r_rate);
    w_lit  = (r_bright > i_pwm);
    w_led_d = 1'b0;
    unique case (r_mode)
      MODE_OFF:     w_led_d = 1'b0;
      MODE_ON:      w_led_d = 1'b1;
      MODE_BLINK:   w_led_d = r_phase;
      MODE_BREATHE: w_led_d = w_lit;
      default:      w_led_d = 1'b0;
    endcase
  end

  // A write takes priority over any tick/step in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= MODE_OFF;
      r_rate     <= '0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_bright   <= '0;
      r_dir_down <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_led <= w_led_d;
      if (i_we) begin
        r_mode     <= i_mode;
        r_rate     <= i_rate;
        r_cnt      <= '0;
        r_phase    <= 1'b0;
        r_bright   <= '0;
        r_dir_down <= 1'b0;
      end else if (i_tick) begin
        if (w_step) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
          // Triangle ramp: each endpoint is held for exactly one step.
          if (!r_dir_down) begin
            if (r_bright == BrightMax) begin
              r_dir_down <= 1'b1;
              r_bright   <= BrightMax - PWM_BITS'(1);
            end else begin
              r_bright <= r_bright + PWM_BITS'(1);
            end
          end else begin
            if (r_bright == '0) begin
              r_dir_down <= 1'b0;
              r_bright   <= PWM_BITS'(1);
            end else begin
              r_bright <= r_bright - PWM_BITS'(1);
            end
          end
        end else begin
          r_cnt <= r_cnt + RATE_BITS'(1);
        end
      end
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern driver.
//   clk_25mhz, rst_n   - clock, asynchronous active-low reset
//   cfg_we, cfg_ch     - single-cycle config write strobe and channel index
//   cfg_mode, cfg_rate - mode (OFF/ON/BLINK/BREATHE) and step interval minus one
//   led                - registered LED drives, 1 = lit
//   tick               - registered prescaler tick pulse
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned RATE_BITS = 16
) (
  input  logic                 clk_25mhz,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [RATE_BITS-1:0] cfg_rate,
  output logic [CHANNELS-1:0]  led,
  output logic                 tick
);

  localparam int unsigned PRESCALE = calc_prescale(CLK_HZ, TICK_HZ);
  localparam int unsigned PresW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("PRESCALE = CLK_HZ/TICK_HZ must be at least 2");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS must be in 1..16");
  end
  if (PWM_BITS < 4 || PWM_BITS > 12) begin : g_bad_pwm_bits
    $error("PWM_BITS must be in 4..12");
  end

  logic [PresW-1:0]    r_presc;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_tick;
  logic                w_tick;
  logic [CHANNELS-1:0] w_we;

  assign w_tick = (r_presc == PresW'(PRESCALE - 1));

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_pwm   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PresW'(1);
      r_pwm   <= r_pwm + PWM_BITS'(1);
      r_tick  <= w_tick;
    end
  end

  // Indices >= CHANNELS never match, so such writes are dropped.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_we[i] = cfg_we && (cfg_ch == 4'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_channel #(
      .PWM_BITS (PWM_BITS),
      .RATE_BITS(RATE_BITS)
    ) u_channel (
      .i_clk  (clk_25mhz),
      .i_rst_n(rst_n),
      .i_tick (w_tick),
      .i_pwm  (r_pwm),
      .i_we   (w_we[g]),
      .i_mode (led_mode_t'(cfg_mode)),
      .i_rate (cfg_rate),
      .o_led  (led[g])
    );
  end

  assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a reference model pushes the expected {led, tick}
// after every clock edge into a queue; a monitor pops and compares.
module tb_led_pattern_gen;

  localparam int P      = 10;
  localparam int NCH    = 4;
  localparam int PWMB   = 4;
  localparam int BMAX   = (1 << PWMB) - 1;
  localparam int RATEB  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [RATEB-1:0] cfg_rate = '0;
  logic [NCH-1:0]   led;
  logic             tick;

  int checks = 0;
  int failures = 0;

  // Model: per-channel mode, rate and the edge index of the last write.
  int m_mode [NCH];
  int m_rate [NCH];
  int m_w    [NCH];
  int e = 0;
  logic [NCH:0] exp_q[$];

  led_pattern_gen #(
    .CLK_HZ   (100),
    .TICK_HZ  (10),
    .CHANNELS (NCH),
    .PWM_BITS (PWMB),
    .RATE_BITS(RATEB)
  ) dut (
    .clk_25mhz(clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_rate (cfg_rate),
    .led      (led),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  function automatic int tri_level(input int s);
    int pos;
    pos = s % (2 * BMAX);
    return (pos <= BMAX) ? pos : (2 * BMAX - pos);
  endfunction

  // LED value driven from state as it stood after edge ep (visible after ep+1).
  function automatic logic [NCH-1:0] model_led(input int ep);
    logic [NCH-1:0] r;
    int t, s;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      t = ep / P - m_w[c] / P;      // ticks seen since the write
      s = t / (m_rate[c] + 1);      // steps fired since the write
      case (m_mode[c])
        1: r[c] = 1'b1;
        2: r[c] = (s % 2) == 1;
        3: r[c] = tri_level(s) > (ep % (1 << PWMB));
        default: r[c] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0;
      m_rate[c] = 0;
      m_w[c]    = 0;
    end
    e = 0;
    exp_q.delete();
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      if (rst_n) begin
        e++;
        exp_q.push_back({model_led(e - 1), (e % P) == 0});
        if (cfg_we && cfg_ch < NCH) begin
          m_mode[cfg_ch] = int'(cfg_mode);
          m_rate[cfg_ch] = int'(cfg_rate);
          m_w[cfg_ch]    = e;
        end
      end
    end
  end

  initial begin : monitor_proc
    logic [NCH:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if ({led, tick} !== x) begin
          failures++;
          $display("FAIL scoreboard edge=%0d led=%b tick=%b expected led=%b tick=%b",
                   e, led, tick, x[NCH:1], x[0]);
        end
      end
    end
  end

  task automatic cfg_write(input int ch, input int mode, input int rate);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_mode = 2'(mode);
    cfg_rate = RATEB'(rate);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== '0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL async_reset led=%b tick=%b expected led=0000 tick=0", led, tick);
    end
    model_reset();
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin : stim_proc
    model_reset();
    rst_n = 1'b0;
    idle(4);
    rst_n = 1'b1;               // released at a negedge
    idle(40);                   // idle: all off, tick every P cycles

    cfg_write(1, 1, 0);
    idle(5);
    cfg_write(1, 0, 0);
    idle(5);

    cfg_write(0, 2, 2);         // blink, step every 3 ticks
    idle(100);

    cfg_write(2, 3, 0);         // breathe, step every tick
    idle(350);

    // ch3 write landing on the same edge as an internal tick
    @(negedge clk);
    while (((e + 1) % P) != 0) @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 4'd3; cfg_mode = 2'd2; cfg_rate = RATEB'(0);
    @(negedge clk);
    cfg_we = 1'b0;
    cfg_write(7, 1, 5);         // out of range: ignored
    idle(50);

    // breathe with slow steps so the PWM duty is seen at steady levels
    cfg_write(2, 3, 3);
    idle(200);

    for (int i = 0; i < 250; i++) begin
      cfg_write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
      idle($urandom_range(0, 40));
    end

    cfg_write(2, 3, 0);
    idle(120);
    async_reset_check();        // mid breathe ramp
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
